// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Optional checksum output is enabled with LOADER_CHECKSUM_EN.
package imem_uart_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    localparam int BAUD_DIV_DEFAULT = 868;
    localparam int LANE_W           = 8;
    localparam int WORD_W           = 32;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, baud counter and RX FSM.
// Held in IDLE while en_i is low; byte_valid/stop_err are one-cycle pulses.
module uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              rxd_i,
    output logic              byte_valid,
    output logic [LANE_W-1:0] byte_data,
    output logic              stop_err,
    output logic              active_o
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    logic              sync1_q;
    logic              sync2_q;
    rx_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [LANE_W-1:0] shift_q;
    logic              valid_q;
    logic [LANE_W-1:0] data_q;
    logic              err_q;
    logic              rxd_s;
    logic              expired;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
        end
    end

    assign rxd_s   = sync2_q;
    assign expired = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (!en_i) begin
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!rxd_s) begin
                            state_q <= ST_START;
                            cnt_q   <= CNT_HALF;
                        end
                    end
                    ST_START: begin
                        if (!expired) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else if (rxd_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= CNT_FULL;
                            bit_q   <= '0;
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (!expired) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            shift_q <= {rxd_s, shift_q[LANE_W-1:1]};
                            cnt_q   <= CNT_FULL;
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'(LANE_W - 1)) begin
                                state_q <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (!expired) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            state_q <= ST_IDLE;
                            if (rxd_s) begin
                                valid_q <= 1'b1;
                                data_q  <= shift_q;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = data_q;
    assign stop_err   = err_q;
    assign active_o   = (state_q != ST_IDLE);

endmodule

// File: rtl/imem_uart_loader.sv
// Packs UART bytes little-endian into words and writes them to imem port B.
// Define LOADER_CHECKSUM_EN to add an 8-bit running checksum output.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_imem,
    input  logic                  uart_rxd,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-3:0] imem_wr_addr,
    output logic [WORD_W-1:0]     imem_wr_data,
    output logic                  busy,
    output logic                  frame_err,
    output logic [ADDR_WIDTH-2:0] word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]            checksum
`endif
);

    localparam logic [ADDR_WIDTH-2:0] CNT_MAX =
        (ADDR_WIDTH-1)'(1) << (ADDR_WIDTH - 2);

    logic                  byte_valid;
    logic [LANE_W-1:0]     byte_data;
    logic                  stop_err;
    logic                  rx_active;

    logic                  load_q;
    logic                  flush_q;
    logic                  ferr_q;
    logic [1:0]            idx_q;
    logic [1:0]            idx_d;
    logic [ADDR_WIDTH-3:0] addr_q;
    logic [ADDR_WIDTH-2:0] cnt_q;
    logic [WORD_W-1:0]     word_q;
    logic                  rise;
    logic                  fall;
    logic                  full_wr;
    logic                  word_done;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .en_i       (load_imem),
        .rxd_i      (uart_rxd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err),
        .active_o   (rx_active)
    );

    assign rise      = load_imem & ~load_q;
    assign fall      = ~load_imem & load_q;
    assign full_wr   = byte_valid & (idx_q == 2'd3);
    assign word_done = full_wr | flush_q;
    assign idx_d     = byte_valid ? idx_q + 2'd1 : idx_q;

    // Flush is decided on the post-byte index so a word completing on the
    // falling edge is written once, not twice
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_q  <= 1'b0;
            flush_q <= 1'b0;
            ferr_q  <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            load_q  <= load_imem;
            flush_q <= 1'b0;
            if (rise) begin
                ferr_q <= 1'b0;
                idx_q  <= '0;
                addr_q <= '0;
                cnt_q  <= '0;
                word_q <= '0;
            end else begin
                if (stop_err) begin
                    ferr_q <= 1'b1;
                end
                if (word_done) begin
                    word_q <= '0;
                end else if (byte_valid) begin
                    word_q[{idx_q, 3'b000} +: LANE_W] <= byte_data;
                end
                idx_q <= flush_q ? 2'd0 : idx_d;
                if (word_done) begin
                    addr_q <= addr_q + 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                flush_q <= fall & (idx_d != 2'd0);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (rise) begin
            sum_q <= '0;
        end else if (byte_valid) begin
            sum_q <= sum_q + byte_data;
        end
    end

    assign checksum = sum_q;
`endif

    assign imem_wr_en   = word_done;
    assign imem_wr_addr = addr_q;
    assign imem_wr_data = flush_q ? word_q
                                  : {byte_data, word_q[WORD_W-LANE_W-1:0]};
    assign busy         = rx_active | byte_valid | flush_q;
    assign frame_err    = ferr_q;
    assign word_count   = cnt_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader at BAUD_DIV=16.
// Build with LOADER_CHECKSUM_EN defined to also check the checksum port.
module tb_imem_uart_loader;

    localparam int BD = 16;
    localparam int AW = 16;

    typedef struct packed {
        logic [AW-3:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_imem = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          imem_wr_en;
    logic [AW-3:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          busy;
    logic          frame_err;
    logic [AW-2:0] word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    wr_t exp_q[$];
    wr_t mon_e;
    int  vectors = 0;
    int  miscompares = 0;

    imem_uart_loader #(
        .BAUD_DIV   (BD),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_imem    (load_imem),
        .uart_rxd     (uart_rxd),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .busy         (busy),
        .frame_err    (frame_err),
`ifdef LOADER_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (imem_wr_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         imem_wr_addr, imem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.addr !== imem_wr_addr || mon_e.data !== imem_wr_data) begin
                    miscompares++;
                    $display("FAIL write: got addr %h data %h, required addr %h data %h",
                             imem_wr_addr, imem_wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [AW-3:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (BD) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BD) tick();
        end
        uart_rxd = stop;
        repeat (BD) tick();
        uart_rxd = 1'b1;
        repeat (BD) tick();
    endtask

    task automatic restart_load();
        load_imem = 1'b0;
        repeat (4) tick();
        load_imem = 1'b1;
        repeat (4) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(imem_wr_en), 32'd0);
        chk({tag, "_addr"}, 32'(imem_wr_addr), 32'd0);
        chk({tag, "_data"}, imem_wr_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Basic word write
        load_imem = 1'b1;
        repeat (2) tick();
        expect_wr(14'd0, 32'h0000_0513);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("t1_word_count", 32'(word_count), 32'd1);

        // Consecutive words, then partial-word flush
        restart_load();
        expect_wr(14'd0, 32'h0403_0201);
        expect_wr(14'd1, 32'h0807_0605);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 1'b1);
        end
        chk("t2_word_count", 32'(word_count), 32'd2);
        expect_wr(14'd2, 32'h0000_BBAA);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        load_imem = 1'b0;
        repeat (4) tick();
        chk("t3_word_count", 32'(word_count), 32'd3);
        chk("t3_busy", 32'(busy), 32'd0);

        // Framing error is sticky and the bad byte is dropped
        load_imem = 1'b1;
        repeat (2) tick();
        chk("t4_frame_err_clear", 32'(frame_err), 32'd0);
        send_byte(8'h55, 1'b0);
        chk("t4_frame_err_set", 32'(frame_err), 32'd1);
        expect_wr(14'd0, 32'h4433_2211);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        chk("t4_frame_err_sticky", 32'(frame_err), 32'd1);
        chk("t4_word_count", 32'(word_count), 32'd1);

        // Reset during DATA bit 4 of the second byte
        restart_load();
        send_byte(8'h11, 1'b1);
        uart_rxd = 1'b0;
        repeat (BD) tick();
        for (int i = 0; i < 4; i++) begin
            uart_rxd = 1'(8'h22 >> i);
            repeat (BD) tick();
        end
        uart_rxd = 1'b0;
        repeat (BD / 2) tick();
        chk("t5_busy_mid_byte", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        chk_all_zero("t5_reset");
        reset = 1'b1;
        uart_rxd = 1'b1;
        repeat (200) tick();
        chk("t5_word_count_after", 32'(word_count), 32'd0);
        expect_wr(14'd0, 32'hEFBE_ADDE);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        chk("t5_word_count", 32'(word_count), 32'd1);

        // Glitch rejection
        restart_load();
        uart_rxd = 1'b0;
        repeat (3) tick();
        uart_rxd = 1'b1;
        repeat (40) tick();
        chk("t6_busy_after_glitch", 32'(busy), 32'd0);
        expect_wr(14'd0, 32'h2010_01FF);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        chk("t6_word_count", 32'(word_count), 32'd1);
        chk("t6_frame_err", 32'(frame_err), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("t6_checksum", 32'(checksum), 32'h30);
`endif

        // Word-aligned end of load must not flush
        load_imem = 1'b0;
        repeat (10) tick();
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Hardware instruction-RAM loader that receives a program image over UART (8N1) and writes it into the SoC instruction memory.
- It is the write-side replacement for the bench backdoor load. It is active while `load_imem` is high.
- It packs received bytes little-endian into 32-bit words and issues one-cycle word writes to the imem write port.
- It sits between the top-level `uart0_rxd` pin and the imem port-B write interface.

Parameters:
- BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- ADDR_WIDTH, 16, imem byte-address width (64 KiB); word address is ADDR_WIDTH-2 bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- load_imem  input  1  load-mode enable; loader operates only while high
- uart_rxd  input  1  asynchronous UART receive line, idle high
- imem_wr_en  output  1  one-cycle word write strobe
- imem_wr_addr  output  ADDR_WIDTH-2  word address of the write
- imem_wr_data  output  32  write word; first received byte lands in [7:0]
- busy  output  1  high while a byte is being received or a write is pending
- frame_err  output  1  sticky; set when a received stop bit is 0
- word_count  output  ADDR_WIDTH-1  number of words written since the load started

Behaviour:
- **Reset** (`reset`=0 at a clk edge):
  - All outputs are 0, FSM goes to IDLE, and the synchronizer flops are set to 1.
  - Reset during a byte aborts it; partial bytes and partial words are discarded.
- **Input synchronizer:** `uart_rxd` passes through a 2-flop synchronizer, so 2 cycles of latency are added before the FSM sees an edge.
- **Load start:** a rising edge of `load_imem` clears the word address, `word_count`, the byte index and `frame_err`.
- **RX FSM:**
  - IDLE: on synced rxd = 0, go to START and load the baud counter with BAUD_DIV/2-1.
  - START: when the counter expires, resample. If rxd = 1 (glitch), return to IDLE. Otherwise reload BAUD_DIV-1 and go to DATA with bit index 0.
  - DATA: sample at each counter expiry, LSB first, into a shift register. After bit 7 go to STOP.
  - STOP: sample at counter expiry.
    - Sample = 1: byte is valid; return to IDLE.
    - Sample = 0: set `frame_err`, drop the byte, return to IDLE without advancing the byte index.
  - While `load_imem` = 0 the FSM is held in IDLE and rxd is ignored.
- **Word packer:**
  - A 2-bit byte index selects the lane; byte k goes to bits [8k+7:8k].
  - When the byte with index 3 is accepted, `imem_wr_en` = 1 for exactly one cycle, on the cycle after the stop-bit sample.
  - `imem_wr_addr` and `imem_wr_data` are valid in that cycle.
  - The word address and `word_count` increment after the write. The address wraps from all-ones to 0; `word_count` saturates at 2^(ADDR_WIDTH-2).
- **Load end:**
  - Falling edge of `load_imem` with the byte index ≠ 0: one flush write is issued on the next cycle, with unfilled lanes set to 0. The index is then cleared.
  - Falling edge during an in-flight byte: the byte is abandoned.
- **Simultaneous events:** if `load_imem` falls in the same cycle a fourth byte completes, the full-word write takes priority and no extra flush write occurs.
- **busy:** high from START entry until the corresponding write (or IDLE return) completes.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- **Defined:**
  - Adds an output port `checksum` (8 bits): the modulo-256 sum of all valid received bytes.
  - It is cleared on the load-start edge.
  - Framing-error bytes and flush padding are excluded.
- **Undefined:** the port and its adder are absent.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, START, DATA, STOP);
  - BAUD_DIV default constant;
  - byte-lane width constant (8);
  - word width constant (32).
- One natural sub-module, `uart_rx_byte`: synchronizer, baud counter and RX FSM, with outputs `byte_valid`, `byte_data` and `stop_err`.
- The top module does packing, addressing, load control and `busy`.

Test Plan (BAUD_DIV=16):
1. **Basic word write:** `load_imem`=1, send bytes 0x13, 0x05, 0x00, 0x00.
   - Expect exactly one `imem_wr_en` pulse with addr 0 and data 0x00000513, on the cycle after the 4th stop sample.
   - Expect `word_count`=1.
2. **Consecutive words:** send 8 bytes 0x01..0x08.
   - Expect writes 0x04030201 at addr 0 and 0x08070605 at addr 1; `word_count`=2.
3. **Partial-word flush:** send 0xAA, 0xBB, then drop `load_imem`.
   - Expect one flush write with data 0x0000BBAA at the current addr on the next cycle.
4. **Framing error:** send 0x55 with stop bit 0, then 0x11, 0x22, 0x33, 0x44.
   - Expect `frame_err`=1 (sticky) and a single write 0x44332211 at addr 0.
5. **Reset mid-operation:** assert `reset`=0 during DATA bit 4 of byte 2.
   - Expect all outputs at 0 the next cycle, with no write.
   - Expect a new 4-byte sequence after reset to be written at addr 0.
6. **Glitch rejection and checksum:** drive a 3-cycle low glitch on rxd, then send 0xFF, 0x01, 0x10, 0x20.
   - Expect no byte from the glitch and a single write 0x201001FF.
   - With LOADER_CHECKSUM_EN defined, expect `checksum`=0x30.
